// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: op encodings, FSM states and step default.
// Optional feature macro: SHIFT_SEQ_ARITH_EN (arithmetic right shift with sign fill).
package shift_sequencer_pkg;

  localparam logic [1:0] SHOP_SLL = 2'b00;
  localparam logic [1:0] SHOP_SRL = 2'b01;
  localparam logic [1:0] SHOP_SRA = 2'b10;

  localparam int STEP_MAX_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Reserved op 11 falls through to a left shift.
  function automatic logic is_right(input logic [1:0] op);
    return (op == SHOP_SRL) || (op == SHOP_SRA);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift stage: moves the word by 0..STEP_MAX bits in either direction,
// optionally filling vacated high bits with the fill bit on right shifts.
module shift_step
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int STEP_MAX = STEP_MAX_DEFAULT,
  parameter int SW       = $clog2(STEP_MAX + 1)
) (
  input  logic [WIDTH-1:0] word,
  input  logic [SW-1:0]    step,
  input  logic             right,
  input  logic             fill,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] fill_mask;

  assign shifted   = right ? (word >> step) : (word << step);
  // Mask covers exactly the top `step` bits vacated by a right shift.
  assign fill_mask = (right && fill) ? ~({WIDTH{1'b1}} >> step) : {WIDTH{1'b0}};
  assign result    = shifted | fill_mask;

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel-free shifter: applies up to STEP_MAX bits of shift per cycle.
// Optional feature macro: SHIFT_SEQ_ARITH_EN enables sign fill for op 10.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int STEP_MAX = STEP_MAX_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [1:0]               in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam int SW  = $clog2(STEP_MAX + 1);
  localparam logic [SHW-1:0] STEP_LIM = SHW'(STEP_MAX);

  state_t           state;
  logic [WIDTH-1:0] word;
  logic [1:0]       op;
  logic [SHW-1:0]   remaining;
  logic [SW-1:0]    step;
  logic [SHW-1:0]   step_wide;
  logic             fill;
  logic [WIDTH-1:0] step_word;

  assign step      = (remaining < STEP_LIM) ? remaining[SW-1:0] : SW'(STEP_MAX);
  assign step_wide = SHW'(step);

`ifdef SHIFT_SEQ_ARITH_EN
  // The working word keeps the operand sign bit through every arithmetic step.
  assign fill = (op == SHOP_SRA) & word[WIDTH-1];
`else
  assign fill = 1'b0;
`endif

  shift_step #(
    .WIDTH    (WIDTH),
    .STEP_MAX (STEP_MAX)
  ) u_step (
    .word   (word),
    .step   (step),
    .right  (is_right(op)),
    .fill   (fill),
    .result (step_word)
  );

  // Sequencer FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state     <= ST_IDLE;
      word      <= {WIDTH{1'b0}};
      op        <= SHOP_SLL;
      remaining <= {SHW{1'b0}};
      out_valid <= 1'b0;
      out_data  <= {WIDTH{1'b0}};
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            word      <= in_data;
            op        <= in_op;
            remaining <= in_shamt;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            if (in_shamt == {SHW{1'b0}}) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              out_data  <= in_data;
            end else begin
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          word      <= step_word;
          remaining <= remaining - step_wide;
          if (remaining == step_wide) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            out_data  <= step_word;
          end
        end
        ST_DONE: begin
          // in_ready stays low this cycle, so no accept can overlap the return to IDLE.
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_data  <= {WIDTH{1'b0}};
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          remaining <= {SHW{1'b0}};
          out_valid <= 1'b0;
          out_data  <= {WIDTH{1'b0}};
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits; SHALL be a power of two, 8 or greater.
REQ-002 Parameter STEP_MAX, default 4: maximum shift distance applied per cycle; SHALL be 1 to 4.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port flush, input, 1: synchronous abort of any in-flight operation.
REQ-006 Port in_valid, input, 1: request present.
REQ-007 Port in_ready, output, 1: block can accept a request.
REQ-008 Port in_data, input, WIDTH: operand.
REQ-009 Port in_shamt, input, log2(WIDTH): shift amount.
REQ-010 Port in_op, input, 2: 00 logical left, 01 logical right, 10 arithmetic right, 11 reserved (treated as 00).
REQ-011 Port out_valid, output, 1: result present.
REQ-012 Port out_ready, input, 1: consumer takes result.
REQ-013 Port out_data, output, WIDTH: shifted result.
REQ-014 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have three states (IDLE, SHIFT, DONE), with in_ready high only in IDLE.
REQ-016 Accept occurs when in_valid and in_ready are both high in IDLE: latch in_data, in_op and in_shamt into remaining; go to DONE if in_shamt is 0, otherwise go to SHIFT.
REQ-017 Each SHIFT cycle: step = min(remaining, STEP_MAX); working word shifted by step per op; remaining reduced by step; go to DONE when the new remaining is 0.
REQ-018 Vacated bits SHALL be 0 for logical ops and a copy of the operand MSB for arithmetic right.
REQ-019 out_valid SHALL rise exactly 1 + ceil(shamt/STEP_MAX) cycles after the accept edge.
REQ-020 In DONE: out_valid high; out_data held stable until the cycle where out_ready is high, then return to IDLE.
REQ-021 Back-to-back: no accept in the cycle of the DONE-to-IDLE transition; the next accept is possible at the earliest in the following cycle.
REQ-022 Inputs in_data, in_shamt and in_op SHALL be ignored outside the accept cycle.
REQ-023 flush high: go to IDLE next cycle; discard any result; out_valid low.
REQ-024 flush and in_valid both high in IDLE: flush wins; no accept.
REQ-025 out_data SHALL be 0 whenever out_valid is low.

Reset
REQ-026 reset high SHALL put the FSM in IDLE on the next edge, from any state including mid-SHIFT.
REQ-027 Reset values SHALL be: working word 0, remaining 0, out_valid 0, out_data 0, busy 0, in_ready 1.
REQ-028 reset SHALL take priority over flush and over every handshake.

Configuration
REQ-029 Macro SHIFT_SEQ_ARITH_EN, when defined, SHALL make op 10 perform arithmetic right shift with sign fill.
REQ-030 When SHIFT_SEQ_ARITH_EN is undefined, op 10 SHALL behave as op 01 (zero fill), and the sign-fill logic SHALL be absent.

Structure
REQ-031 A shared package SHALL hold the op encodings (SHOP_SLL, SHOP_SRL, SHOP_SRA), the FSM state typedef and the STEP_MAX default.
REQ-032 A combinational sub-module shift_step SHALL take the word, a step of 0 to STEP_MAX, the direction and the fill bit, and return the shifted word; shift_sequencer SHALL instantiate it once.
REQ-033 No other sub-modules SHALL be used; the FSM, counter and registers SHALL be in shift_sequencer.

Verification
REQ-034 Left shift: in_data 0x00000001, in_shamt 31, in_op 00 -> out_valid at +9 cycles, out_data 0x80000000.
REQ-035 Logical right shift: in_data 0x80000000, in_shamt 4, in_op 01 -> out_valid at +2 cycles, out_data 0x08000000.
REQ-036 Arithmetic right: in_data 0x80000000, in_shamt 3, in_op 10 -> out_data 0xF0000000 with SHIFT_SEQ_ARITH_EN defined, 0x10000000 without it.
REQ-037 Zero shift with backpressure: in_data 0xDEADBEEF, in_shamt 0, out_ready held low 5 cycles -> out_valid at +1 cycle, out_data 0xDEADBEEF held stable for all 5 cycles, in_ready low throughout, IDLE after out_ready rises.
REQ-038 Abort: reset, then separately flush, asserted in the 3rd SHIFT cycle of a shamt-31 op -> IDLE next cycle, out_valid never asserted, next request (shamt 5) correct at +3 cycles.
